cc_depuncture: RTL and testbench

CC_DEPUNCTURE -- requirements
Module: cc_depuncture

---
 rtl/wimax_fec_pkg.sv | 21 ++
 rtl/cc_punct_pattern.sv | 16 +
 rtl/cc_depuncture.sv | 151 +++++++++++++++
 tb/tb_cc_depuncture.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wimax_fec_pkg.sv
// rtl/wimax_fec_pkg.sv - rate encodings and puncturing tables shared by the CC encoder and depuncturer
package wimax_fec_pkg;

  typedef enum logic [1:0] {
    CC_RATE_1_2 = 2'd0,
    CC_RATE_2_3 = 2'd1,
    CC_RATE_3_4 = 2'd2,
    CC_RATE_5_6 = 2'd3
  } cc_rate_e;

  typedef enum logic {
    X_NEXT = 1'b0,
    Y_NEXT = 1'b1
  } cc_slot_e;

  // Indexed by cc_rate_e; bit k of a mask says whether pair k carries that soft bit.
  localparam logic [3:0][2:0] CC_PERIOD = {3'd5, 3'd3, 3'd2, 3'd1};
  localparam logic [3:0][4:0] CC_X_MASK = {5'b10101, 5'b00101, 5'b00001, 5'b00001};
  localparam logic [3:0][4:0] CC_Y_MASK = {5'b01011, 5'b00011, 5'b00011, 5'b00001};

endpackage

// File: rtl/cc_punct_pattern.sv
// rtl/cc_punct_pattern.sv - combinational lookup of X/Y presence and period end for pair k
module cc_punct_pattern
  import wimax_fec_pkg::*;
(
  input  cc_rate_e   rate,
  input  logic [2:0] k,
  output logic       has_x,
  output logic       has_y,
  output logic       last
);

  assign has_x = CC_X_MASK[rate][k];
  assign has_y = CC_Y_MASK[rate][k];
  assign last  = (k == 3'(CC_PERIOD[rate] - 3'd1));

endmodule

// File: rtl/cc_depuncture.sv
// rtl/cc_depuncture.sv - rebuilds X/Y soft-bit pairs from a punctured stream, erasing dropped slots
// Optional CC_DEPUNCTURE_EOF_EN adds in_eof to flush a partial pair at end of frame.
module cc_depuncture
  import wimax_fec_pkg::*;
#(
  parameter int w = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [w-1:0] in_bits,
  input  logic         in_valid,
  input  logic         in_sof,
`ifdef CC_DEPUNCTURE_EOF_EN
  input  logic         in_eof,
`endif
  output logic         in_ready,
  input  logic [1:0]   cc_rate,
  output logic [w-1:0] out_x,
  output logic [w-1:0] out_y,
  output logic         out_x_erase,
  output logic         out_y_erase,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [2:0]   k_q, k_d;
  cc_slot_e     slot_q, slot_d;
  cc_rate_e     rate_q, rate_d;
  logic [w-1:0] x_hold_q, x_hold_d;
  logic [w-1:0] out_x_q, out_x_d, out_y_q, out_y_d;
  logic         out_xe_q, out_xe_d, out_ye_q, out_ye_d;
  logic         out_valid_q, out_valid_d;

  logic         accept;
  logic         emit;
  cc_rate_e     rate_use;
  logic [2:0]   k_use;
  cc_slot_e     slot_use;
  logic         pat_has_x, pat_has_y, pat_last;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // A start-of-frame restarts the pattern on this very input.
  always_comb begin
    rate_use = rate_q;
    k_use    = k_q;
    slot_use = slot_q;
    if (in_sof) begin
      rate_use = cc_rate_e'(cc_rate);
      k_use    = 3'd0;
      slot_use = X_NEXT;
    end
  end

  cc_punct_pattern u_pattern (
    .rate  (rate_use),
    .k     (k_use),
    .has_x (pat_has_x),
    .has_y (pat_has_y),
    .last  (pat_last)
  );

  always_comb begin
    k_d         = k_q;
    slot_d      = slot_q;
    rate_d      = rate_q;
    x_hold_d    = x_hold_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_xe_d    = out_xe_q;
    out_ye_d    = out_ye_q;
    out_valid_d = out_valid_q && !out_ready;
    emit        = 1'b0;
    if (accept) begin
      rate_d = rate_use;
      k_d    = k_use;
      slot_d = slot_use;
      if (slot_use == Y_NEXT) begin
        emit     = 1'b1;
        out_x_d  = x_hold_q;
        out_xe_d = 1'b0;
        out_y_d  = in_bits;
        out_ye_d = 1'b0;
      end else if (pat_has_x && pat_has_y) begin
        x_hold_d = in_bits;
        slot_d   = Y_NEXT;
`ifdef CC_DEPUNCTURE_EOF_EN
        if (in_eof) begin
          emit     = 1'b1;
          out_x_d  = in_bits;
          out_xe_d = 1'b0;
          out_y_d  = '0;
          out_ye_d = 1'b1;
        end
`endif
      end else if (pat_has_x) begin
        emit     = 1'b1;
        out_x_d  = in_bits;
        out_xe_d = 1'b0;
        out_y_d  = '0;
        out_ye_d = 1'b1;
      end else begin
        emit     = 1'b1;
        out_x_d  = '0;
        out_xe_d = 1'b1;
        out_y_d  = in_bits;
        out_ye_d = 1'b0;
      end
      if (emit) begin
        out_valid_d = 1'b1;
        slot_d      = X_NEXT;
        k_d         = pat_last ? 3'd0 : k_use + 3'd1;
`ifdef CC_DEPUNCTURE_EOF_EN
        if (in_eof) k_d = 3'd0;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q         <= 3'd0;
      slot_q      <= X_NEXT;
      rate_q      <= CC_RATE_1_2;
      x_hold_q    <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_xe_q    <= 1'b0;
      out_ye_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      k_q         <= k_d;
      slot_q      <= slot_d;
      rate_q      <= rate_d;
      x_hold_q    <= x_hold_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_xe_q    <= out_xe_d;
      out_ye_q    <= out_ye_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_x       = out_x_q;
  assign out_y       = out_y_q;
  assign out_x_erase = out_xe_q;
  assign out_y_erase = out_ye_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_cc_depuncture.sv
// tb/tb_cc_depuncture.sv - self-checking bench for cc_depuncture against a mother-stream position model
module tb_cc_depuncture;

  localparam int W = 4;
`ifdef CC_DEPUNCTURE_EOF_EN
  localparam bit EOF_EN = 1'b1;
`else
  localparam bit EOF_EN = 1'b0;
`endif

  typedef logic [2*W+1:0] pair_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_bits;
  logic         in_valid, in_sof, in_ready;
`ifdef CC_DEPUNCTURE_EOF_EN
  logic         in_eof_v;
`endif
  logic [1:0]   cc_rate;
  logic [W-1:0] out_x, out_y;
  logic         out_x_erase, out_y_erase, out_valid, out_ready;

  int n_checks = 0;
  int n_err    = 0;

  pair_t exp_q[$];
  pair_t got_q[$];
  pair_t want[$];

  // Kept soft bits per period as positions in the unpunctured X0 Y0 X1 Y1 ... stream.
  int kp[4][6] = '{'{0, 1, 0, 0, 0, 0}, '{0, 1, 3, 0, 0, 0}, '{0, 1, 3, 4, 0, 0}, '{0, 1, 3, 4, 7, 8}};
  int kc[4]    = '{2, 3, 4, 6};
  int kper[4]  = '{1, 2, 3, 5};

  int m_rate, m_idx, m_x, m_y;
  bit m_hx, m_hy;

  cc_depuncture #(.w(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_bits     (in_bits),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
`ifdef CC_DEPUNCTURE_EOF_EN
    .in_eof      (in_eof_v),
`endif
    .in_ready    (in_ready),
    .cc_rate     (cc_rate),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_x_erase (out_x_erase),
    .out_y_erase (out_y_erase),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic pair_t pk(input int x, input int y, input bit xe, input bit ye);
    return {x[W-1:0], y[W-1:0], xe, ye};
  endfunction

  task automatic add_want(input int x, input int y, input bit xe, input bit ye);
    want.push_back(pk(x, y, xe, ye));
  endtask

  task automatic check_got(input string tag);
    check({tag, "_count"}, got_q.size(), want.size());
    foreach (want[i])
      if (i < got_q.size()) check($sformatf("%s_%0d", tag, i), got_q[i], want[i]);
    want.delete();
  endtask

  task automatic model_reset();
    m_rate = 0; m_idx = 0; m_hx = 0; m_hy = 0; m_x = 0; m_y = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input int b, input bit sof, input bit eof);
    int c, p, pos, nxt;
    if (sof) begin
      m_rate = int'(cc_rate); m_idx = 0; m_hx = 0; m_hy = 0;
    end
    c   = kc[m_rate];
    p   = kper[m_rate];
    pos = (m_idx / c) * 2 * p + kp[m_rate][m_idx % c];
    nxt = ((m_idx + 1) / c) * 2 * p + kp[m_rate][(m_idx + 1) % c];
    if (pos % 2 == 0) begin m_x = b; m_hx = 1; end
    else begin m_y = b; m_hy = 1; end
    m_idx++;
    if ((nxt / 2 != pos / 2) || eof) begin
      exp_q.push_back(pk(m_hx ? m_x : 0, m_hy ? m_y : 0, !m_hx, !m_hy));
      m_hx = 0; m_hy = 0;
      if (eof) m_idx = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int b, input bit sof, input bit eof);
    int n;
    n = 0;
    in_bits  = b[W-1:0];
    in_sof   = sof;
    in_valid = 1'b1;
`ifdef CC_DEPUNCTURE_EOF_EN
    in_eof_v = eof;
`endif
    forever begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(b, sof, eof);
        break;
      end
      n++;
      if (n > 50) begin
        check("in_ready_timeout", 0, 1);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
`ifdef CC_DEPUNCTURE_EOF_EN
    in_eof_v = 1'b0;
`endif
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, {out_x, out_y, out_x_erase, out_y_erase}, 0);
    model_reset();
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin : monitor
    pair_t cur, prev_pair;
    bit prev_stall;
    prev_stall = 0;
    prev_pair  = '0;
    forever begin
      @(negedge clk);
      cur = {out_x, out_y, out_x_erase, out_y_erase};
      if (reset) prev_stall = 0;
      else begin
        if (prev_stall) begin
          check("hold_valid", out_valid, 1);
          check("hold_pair", cur, prev_pair);
        end
        if (out_valid && out_ready) begin
          got_q.push_back(cur);
          if (exp_q.size() == 0) check("unexpected_pair", cur, 0);
          else check("pair_vs_model", cur, exp_q.pop_front());
        end
        prev_stall = out_valid && !out_ready;
        prev_pair  = cur;
      end
    end
  end

  initial begin : stimulus
    bit rand_on;
    reset = 1'b1; in_valid = 0; in_sof = 0; in_bits = '0; cc_rate = 2'd0; out_ready = 1'b1;
`ifdef CC_DEPUNCTURE_EOF_EN
    in_eof_v = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", {out_x, out_y, out_x_erase, out_y_erase}, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b0;

    // Before any sof the block runs at rate 1/2, whatever cc_rate shows.
    cc_rate = 2'd3;
    send(1, 0, 0); send(2, 0, 0);
    idle(3);
    add_want(1, 2, 0, 0);
    check_got("no_sof_r12");

    got_q.delete();
    cc_rate = 2'd0;
    send(1, 1, 0); send(2, 0, 0);
    check("r12_lat_a", out_valid, 1);
    send(3, 0, 0);
    check("r12_x_only_no_out", out_valid, 0);
    send(4, 0, 0);
    check("r12_lat_b", out_valid, 1);
    idle(3);
    add_want(1, 2, 0, 0); add_want(3, 4, 0, 0);
    check_got("r12");

    got_q.delete();
    cc_rate = 2'd3;
    send(1, 1, 0);
    cc_rate = 2'd0;
    for (int i = 2; i <= 8; i++) send(i, 0, 0);
    idle(3);
    add_want(1, 2, 0, 0); add_want(0, 3, 1, 0); add_want(4, 0, 0, 1);
    add_want(0, 5, 1, 0); add_want(6, 0, 0, 1); add_want(7, 8, 0, 0);
    check_got("r56");

    got_q.delete();
    cc_rate = 2'd2;
    send(1, 1, 0); send(2, 0, 0);
    out_ready = 1'b0;
    fork
      send(3, 0, 0);
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_in_ready", in_ready, 0);
          check("bp_pair", {out_valid, out_x, out_y, out_x_erase, out_y_erase}, {1'b1, pk(1, 2, 0, 0)});
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    send(4, 0, 0); send(5, 0, 0); send(6, 0, 0);
    idle(3);
    add_want(1, 2, 0, 0); add_want(0, 3, 1, 0); add_want(4, 0, 0, 1); add_want(5, 6, 0, 0);
    check_got("r34_bp");

    got_q.delete();
    cc_rate = 2'd1;
    send(1, 1, 0); send(9, 1, 0); send(5, 0, 0); send(6, 0, 0);
    idle(3);
    add_want(9, 5, 0, 0); add_want(0, 6, 1, 0);
    check_got("r23_sof_discard");

    out_ready = 1'b0;
    cc_rate = 2'd1;
    send(5, 1, 0); send(6, 0, 0);
    do_reset("rst_held");
    out_ready = 1'b1;
    cc_rate = 2'd3;
    send(1, 1, 0);
    do_reset("rst_mid_pair");
    got_q.delete();
    for (int i = 4; i <= 7; i++) send(i, 0, 0);
    idle(3);
    add_want(4, 5, 0, 0); add_want(6, 7, 0, 0);
    check_got("after_rst");

`ifdef CC_DEPUNCTURE_EOF_EN
    got_q.delete();
    cc_rate = 2'd0;
    send(7, 1, 1);
    idle(3);
    add_want(7, 0, 0, 1);
    check_got("eof_r12");
`endif

    rand_on = 1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int f = 0; f < 40; f++) begin
          int len;
          bit use_sof;
          len     = $urandom_range(1, 20);
          use_sof = ($urandom_range(0, 4) != 0);
          for (int i = 0; i < len; i++) begin
            bit eof;
            idle($urandom_range(0, 2));
            cc_rate = 2'($urandom_range(0, 3));
            eof = EOF_EN && (i == len - 1) && ($urandom_range(0, 1) == 1);
            send($urandom_range(0, 15), use_sof && (i == 0), eof);
          end
        end
        rand_on = 0;
      end
    join
    out_ready = 1'b1;
    idle(5);
    check("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
